// File: rtl/nibble_alu_sequencer_if.sv
// Request/result bundle between the command front end and the nibble ALU sequencer.
interface nibble_alu_sequencer_if;
  logic       i_data_rdy;
  logic       i_substrate_signal;
  logic [7:0] i_r1;
  logic [7:0] i_r2;
  logic       i_cin;
  logic [7:0] o_sum;
  logic       o_cout;
  logic       o_ovf;
  logic       o_rdy;
  logic       o_busy;
  logic [3:0] o_drop_cnt;

  modport master (
    output i_data_rdy, i_substrate_signal, i_r1, i_r2, i_cin,
    input  o_sum, o_cout, o_ovf, o_rdy, o_busy, o_drop_cnt
  );

  modport slave (
    input  i_data_rdy, i_substrate_signal, i_r1, i_r2, i_cin,
    output o_sum, o_cout, o_ovf, o_rdy, o_busy, o_drop_cnt
  );
endinterface

// File: rtl/nibble_alu_sequencer.sv
// 8-bit add/subtract built from one 4-bit adder used over two passes (low nibble, then high).
// Includes the shared 4-bit adder leaf so the block stays self-contained.
module fourbit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_alu_sequencer #(
  parameter int unsigned RDY_PULSE_LEN = 2
) (
  input  logic                   i_clk_in,
  input  logic                   i_rst,
  nibble_alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  localparam logic [3:0] PulseLast = 4'(RDY_PULSE_LEN - 1);

  state_e     state_q, state_d;
  logic       rdy_q;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       cin_q, cin_d;
  logic       c_mid_q, c_mid_d;
  logic [3:0] sum_lo_q, sum_lo_d;
  logic [7:0] sum_q, sum_d;
  logic       cout_q, cout_d;
  logic       ovf_q, ovf_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] drop_q, drop_d;

  logic       req;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;

  assign req = bus.i_data_rdy & ~rdy_q;

  // Operand mux is steered purely by state so the adder sees the high nibble only in StHigh.
  assign add_a   = (state_q == StHigh) ? x_q[7:4] : x_q[3:0];
  assign add_b   = (state_q == StHigh) ? y_q[7:4] : y_q[3:0];
  assign add_cin = (state_q == StHigh) ? c_mid_q  : cin_q;

  fourbit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cin_d    = cin_q;
    c_mid_d  = c_mid_q;
    sum_lo_d = sum_lo_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          x_d = bus.i_r1;
          // Subtract as r1 + ~r2 + 1, so carry-out of 1 means no borrow.
          if (bus.i_substrate_signal) begin
            y_d   = ~bus.i_r2;
            cin_d = 1'b1;
          end else begin
            y_d   = bus.i_r2;
            cin_d = bus.i_cin;
          end
          state_d = StLow;
        end
      end
      StLow: begin
        sum_lo_d = add_sum;
        c_mid_d  = add_cout;
        state_d  = StHigh;
      end
      StHigh: begin
        sum_d   = {add_sum, sum_lo_q};
        cout_d  = add_cout;
        ovf_d   = (x_q[7] == y_q[7]) & (add_sum[3] != x_q[7]);
        cnt_d   = 4'd0;
        state_d = StDone;
      end
      StDone: begin
        if (cnt_q == PulseLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (req && (state_q != StIdle) && (drop_q != 4'hf)) begin
      drop_d = drop_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      state_q  <= StIdle;
      rdy_q    <= 1'b0;
      x_q      <= 8'h00;
      y_q      <= 8'h00;
      cin_q    <= 1'b0;
      c_mid_q  <= 1'b0;
      sum_lo_q <= 4'h0;
      sum_q    <= 8'h00;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= 4'h0;
      drop_q   <= 4'h0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= bus.i_data_rdy;
      x_q      <= x_d;
      y_q      <= y_d;
      cin_q    <= cin_d;
      c_mid_q  <= c_mid_d;
      sum_lo_q <= sum_lo_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.o_sum      = sum_q;
  assign bus.o_cout     = cout_q;
  assign bus.o_ovf      = ovf_q;
  assign bus.o_rdy      = (state_q == StDone);
  assign bus.o_busy     = (state_q != StIdle);
  assign bus.o_drop_cnt = drop_q;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Randomized + directed bench for nibble_alu_sequencer; two instances (pulse length 2 and 5)
// share one stimulus stream and are each checked against an arithmetic/timeline model.
module tb_nibble_alu_sequencer;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dr, sub, cin;
  logic [7:0] r1, r2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  nibble_alu_sequencer_if u_if0 ();
  nibble_alu_sequencer_if u_if1 ();

  assign u_if0.i_data_rdy = dr;
  assign u_if0.i_substrate_signal = sub;
  assign u_if0.i_r1 = r1;
  assign u_if0.i_r2 = r2;
  assign u_if0.i_cin = cin;
  assign u_if1.i_data_rdy = dr;
  assign u_if1.i_substrate_signal = sub;
  assign u_if1.i_r1 = r1;
  assign u_if1.i_r2 = r2;
  assign u_if1.i_cin = cin;

  nibble_alu_sequencer #(.RDY_PULSE_LEN(2)) u_dut0 (
    .i_clk_in (clk),
    .i_rst    (rst),
    .bus      (u_if0.slave)
  );

  nibble_alu_sequencer #(.RDY_PULSE_LEN(5)) u_dut1 (
    .i_clk_in (clk),
    .i_rst    (rst),
    .bus      (u_if1.slave)
  );

  // Reference model: per-instance transaction timeline plus the arithmetic result.
  bit         m_prev[2];
  bit         m_active[2];
  int         m_acc[2];
  logic [7:0] m_pend_sum[2];
  bit         m_pend_cout[2];
  bit         m_pend_ovf[2];
  logic [7:0] m_sum[2];
  bit         m_cout[2];
  bit         m_ovf[2];
  int         m_drop[2];

  function automatic int len_of(input int k);
    return (k == 0) ? 2 : 5;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int  res, sres, a, b;
    bit  req, idle;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_prev[k] = 1'b0;
        m_active[k] = 1'b0;
        m_sum[k] = 8'h00;
        m_cout[k] = 1'b0;
        m_ovf[k] = 1'b0;
        m_drop[k] = 0;
      end else begin
        req = dr && !m_prev[k];
        m_prev[k] = dr;
        if (m_active[k] && cyc == m_acc[k] + 2) begin
          m_sum[k] = m_pend_sum[k];
          m_cout[k] = m_pend_cout[k];
          m_ovf[k] = m_pend_ovf[k];
        end
        idle = !m_active[k] || (cyc > m_acc[k] + 2 + len_of(k));
        if (req) begin
          if (idle) begin
            a = int'(r1);
            b = int'(r2);
            if (sub) begin
              res = a - b;
              m_pend_cout[k] = (a >= b);
              sres = int'($signed(r1)) - int'($signed(r2));
            end else begin
              res = a + b + int'(cin);
              m_pend_cout[k] = (res > 255);
              sres = int'($signed(r1)) + int'($signed(r2)) + int'(cin);
            end
            m_pend_sum[k] = res[7:0];
            m_pend_ovf[k] = (sres > 127) || (sres < -128);
            m_active[k] = 1'b1;
            m_acc[k] = cyc;
          end else if (m_drop[k] < 15) begin
            m_drop[k]++;
          end
        end
      end
    end
  endtask

  task automatic compare(input int k, input logic [7:0] s, input logic co, input logic ov,
                         input logic rd, input logic bz, input logic [3:0] dc);
    bit exp_busy, exp_rdy;
    int l;
    l = len_of(k);
    exp_busy = m_active[k] && (cyc <= m_acc[k] + 1 + l);
    exp_rdy  = m_active[k] && (cyc >= m_acc[k] + 2) && (cyc <= m_acc[k] + 1 + l);
    check($sformatf("d%0d_sum", k), 32'(s), 32'(m_sum[k]));
    check($sformatf("d%0d_cout", k), 32'(co), 32'(m_cout[k]));
    check($sformatf("d%0d_ovf", k), 32'(ov), 32'(m_ovf[k]));
    check($sformatf("d%0d_rdy", k), 32'(rd), 32'(exp_rdy));
    check($sformatf("d%0d_busy", k), 32'(bz), 32'(exp_busy));
    check($sformatf("d%0d_drop", k), 32'(dc), 32'(m_drop[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(0, u_if0.o_sum, u_if0.o_cout, u_if0.o_ovf, u_if0.o_rdy, u_if0.o_busy,
            u_if0.o_drop_cnt);
    compare(1, u_if1.o_sum, u_if1.o_cout, u_if1.o_ovf, u_if1.o_rdy, u_if1.o_busy,
            u_if1.o_drop_cnt);
  endtask

  // Single-edge request, then run until both instances are idle; also counts o_rdy width.
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    int rdy0, rdy1;
    rdy0 = 0;
    rdy1 = 0;
    sub = s; r1 = a; r2 = b; cin = c; dr = 1'b1;
    tick();
    dr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (u_if0.o_rdy) rdy0++;
      if (u_if1.o_rdy) rdy1++;
    end
    check("rdy_width_len2", 32'(rdy0), 32'd2);
    check("rdy_width_len5", 32'(rdy1), 32'd5);
  endtask

  initial begin
    rst = 1'b1; dr = 1'b0; sub = 1'b0; cin = 1'b0; r1 = 8'h00; r2 = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_op(1'b0, 8'h3C, 8'h47, 1'b0);
    check("add_ovf_sum", 32'(u_if0.o_sum), 32'h83);
    check("add_ovf_flag", 32'(u_if0.o_ovf), 32'd1);
    run_op(1'b0, 8'hFF, 8'h01, 1'b0);
    check("add_wrap_sum", 32'(u_if0.o_sum), 32'h00);
    check("add_wrap_cout", 32'(u_if0.o_cout), 32'd1);
    run_op(1'b0, 8'hFF, 8'h01, 1'b1);
    check("add_wrap_cin_sum", 32'(u_if1.o_sum), 32'h01);
    run_op(1'b1, 8'h50, 8'h20, 1'b1);
    check("sub_sum", 32'(u_if0.o_sum), 32'h30);
    run_op(1'b1, 8'h10, 8'h20, 1'b0);
    check("sub_borrow_sum", 32'(u_if0.o_sum), 32'hF0);
    check("sub_borrow_cout", 32'(u_if0.o_cout), 32'd0);
    run_op(1'b1, 8'h80, 8'h01, 1'b0);
    check("sub_ovf_sum", 32'(u_if0.o_sum), 32'h7F);
    check("sub_ovf_flag", 32'(u_if0.o_ovf), 32'd1);

    // Level held high: exactly one operation, nothing dropped.
    sub = 1'b0; r1 = 8'h05; r2 = 8'h06; cin = 1'b0; dr = 1'b1;
    repeat (10) tick();
    dr = 1'b0;
    repeat (8) tick();
    check("level_drop", 32'(u_if0.o_drop_cnt), 32'd0);
    check("level_sum", 32'(u_if0.o_sum), 32'h0B);

    // Second edge lands while the first op is in its high pass.
    sub = 1'b0; r1 = 8'h12; r2 = 8'h34; dr = 1'b1;
    tick();
    dr = 1'b0;
    tick();
    r1 = 8'hAA; r2 = 8'h77; sub = 1'b1; dr = 1'b1;
    tick();
    dr = 1'b0;
    repeat (8) tick();
    check("busy_drop_one", 32'(u_if0.o_drop_cnt), 32'd1);
    check("busy_first_sum", 32'(u_if0.o_sum), 32'h46);

    // Continuous toggling: plenty of busy edges, counter must saturate.
    for (int i = 0; i < 80; i++) begin
      dr = ~dr;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      tick();
    end
    dr = 1'b0;
    repeat (8) tick();
    check("drop_sat0", 32'(u_if0.o_drop_cnt), 32'd15);
    check("drop_sat1", 32'(u_if1.o_drop_cnt), 32'd15);

    // Reset during the low pass abandons the operation.
    r1 = 8'h21; r2 = 8'h11; sub = 1'b0; dr = 1'b1;
    tick();
    dr = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(u_if0.o_busy), 32'd0);
    check("rst_mid_sum", 32'(u_if0.o_sum), 32'h00);
    repeat (6) tick();
    run_op(1'b0, 8'h21, 8'h11, 1'b0);
    check("after_rst_sum", 32'(u_if0.o_sum), 32'h32);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      dr  = 1'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
      r1  = 8'($urandom);
      r2  = 8'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; dr = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
